// File: rtl/bus_arbiter_sp_if.sv
// bus_arbiter_sp_if: request/grant/split signals between the arbiter and the bus agents.
interface bus_arbiter_sp_if;
    logic M1_BREQ, M2_BREQ, S_SPLIT, S_SPL_READY;
    logic M1_BGRANT, M2_BGRANT, M1_SPLIT, M2_SPLIT, B_SPL_RESUME, B_SBSY, MSEL;
    modport master (
        input  M1_BREQ, M2_BREQ, S_SPLIT, S_SPL_READY,
        output M1_BGRANT, M2_BGRANT, M1_SPLIT, M2_SPLIT, B_SPL_RESUME, B_SBSY, MSEL
    );
    modport slave (
        output M1_BREQ, M2_BREQ, S_SPLIT, S_SPL_READY,
        input  M1_BGRANT, M2_BGRANT, M1_SPLIT, M2_SPLIT, B_SPL_RESUME, B_SBSY, MSEL
    );
endinterface

// File: rtl/bus_arbiter_sp.sv
// bus_arbiter_sp: two-master fixed-priority arbiter with single split-transaction record.
module bus_arbiter_sp (
    input logic CLK,
    input logic RST,
    bus_arbiter_sp_if.master bus
);
    typedef enum logic [1:0] {IDLE, OWN_M1, OWN_M2, RESUME} state_t;
    state_t state, nxt;
    logic spl_pend, spl_owner, nxt_pend, nxt_owner;
    logic g1, g2, s1, s2, res, msel, g1_n, g2_n;
    always_comb begin
        nxt = state;
        nxt_pend = spl_pend;
        nxt_owner = spl_owner;
        case (state)
            IDLE:
                if (spl_pend && bus.S_SPL_READY) begin
                    nxt = RESUME;
                    nxt_pend = 1'b0;
                end else if (bus.M1_BREQ && !(spl_pend && !spl_owner)) nxt = OWN_M1;
                else if (bus.M2_BREQ && !(spl_pend && spl_owner)) nxt = OWN_M2;
            OWN_M1:
                if (bus.S_SPLIT && !spl_pend) begin
                    nxt = IDLE;
                    nxt_pend = 1'b1;
                    nxt_owner = 1'b0;
                end else if (!bus.M1_BREQ) nxt = IDLE;
            OWN_M2:
                if (bus.S_SPLIT && !spl_pend) begin
                    nxt = IDLE;
                    nxt_pend = 1'b1;
                    nxt_owner = 1'b1;
                end else if (!bus.M2_BREQ) nxt = IDLE;
            default: nxt = spl_owner ? OWN_M2 : OWN_M1;
        endcase
    end
    // Outputs are decoded from next state so every output is a flop aligned with the state.
    assign g1_n = nxt == OWN_M1 || (nxt == RESUME && !nxt_owner);
    assign g2_n = nxt == OWN_M2 || (nxt == RESUME && nxt_owner);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            spl_pend <= 1'b0;
            spl_owner <= 1'b0;
            g1 <= 1'b0;
            g2 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
            res <= 1'b0;
            msel <= 1'b0;
        end else begin
            state <= nxt;
            spl_pend <= nxt_pend;
            spl_owner <= nxt_owner;
            g1 <= g1_n;
            g2 <= g2_n;
            s1 <= nxt_pend && !nxt_owner;
            s2 <= nxt_pend && nxt_owner;
            res <= nxt == RESUME;
            msel <= g2_n ? 1'b1 : g1_n ? 1'b0 : msel;
        end
    end
    assign bus.M1_BGRANT = g1;
    assign bus.M2_BGRANT = g2;
    assign bus.M1_SPLIT = s1;
    assign bus.M2_SPLIT = s2;
    assign bus.B_SPL_RESUME = res;
    assign bus.B_SBSY = spl_pend;
    assign bus.MSEL = msel;
    grant_onehot: assert property (@(posedge CLK) disable iff (RST) !(g1 && g2));
endmodule

// File: tb/tb_bus_arbiter_sp.sv
// tb_bus_arbiter_sp: directed vectors; outputs packed as {g1,g2,s1,s2,resume,sbsy,msel}.
module tb_bus_arbiter_sp;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int checks = 0;
    int failures = 0;
    bus_arbiter_sp_if bus ();
    bus_arbiter_sp dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask
    function automatic logic [6:0] outs();
        return {bus.M1_BGRANT, bus.M2_BGRANT, bus.M1_SPLIT, bus.M2_SPLIT,
                bus.B_SPL_RESUME, bus.B_SBSY, bus.MSEL};
    endfunction
    task automatic cyc(input string tag, input logic [6:0] exp);
        @(posedge CLK);
        #1;
        chk(tag, outs(), exp);
    endtask
    initial begin
        bus.M1_BREQ = 0; bus.M2_BREQ = 0; bus.S_SPLIT = 0; bus.S_SPL_READY = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset", outs(), 7'b0000000);
        RST = 0;
        bus.M1_BREQ = 1; bus.M2_BREQ = 1;
        cyc("m1_first", 7'b1000000);
        cyc("m1_hold", 7'b1000000);
        bus.M1_BREQ = 0;
        cyc("turnaround", 7'b0000000);
        cyc("m2_own", 7'b0100001);
        bus.S_SPLIT = 1;
        cyc("m2_split", 7'b0001011);
        bus.S_SPLIT = 0; bus.M1_BREQ = 1;
        cyc("m1_after_split", 7'b1001010);
        bus.S_SPL_READY = 1;
        cyc("no_preempt", 7'b1001010);
        bus.S_SPLIT = 1;
        cyc("split2_ignored", 7'b1001010);
        bus.S_SPLIT = 0; bus.M1_BREQ = 0;
        cyc("idle_pre_resume", 7'b0001010);
        cyc("resume", 7'b0100101);
        bus.S_SPL_READY = 0;
        cyc("own_after_resume", 7'b0100001);
        bus.M2_BREQ = 0;
        cyc("m2_release", 7'b0000001);
        bus.S_SPL_READY = 1;
        cyc("ready_no_pend", 7'b0000001);
        bus.S_SPL_READY = 0; bus.M1_BREQ = 1;
        cyc("m1_own", 7'b1000000);
        bus.S_SPLIT = 1; bus.M1_BREQ = 0;
        cyc("split_wins_drop", 7'b0010010);
        bus.S_SPLIT = 0; bus.M1_BREQ = 1;
        cyc("parked_ignored", 7'b0010010);
        bus.M2_BREQ = 1;
        cyc("m2_while_m1_parked", 7'b0110011);
        bus.S_SPLIT = 1;
        cyc("owner_unchanged", 7'b0110011);
        bus.S_SPLIT = 0;
        #2 RST = 1;
        #1 chk("async_rst", outs(), 7'b0000000);
        bus.M1_BREQ = 0; bus.M2_BREQ = 0; bus.S_SPL_READY = 1;
        #3 RST = 0;
        cyc("no_resume_1", 7'b0000000);
        cyc("no_resume_2", 7'b0000000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_arbiter_sp.md
BUS_ARBITER_SP -- requirements
Module: bus_arbiter_sp

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset; ports named CLK and RST.
REQ-002 SHALL expose ports (name  direction  width  meaning):
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous active-high reset
- M1_BREQ  in  1  master 1 bus request, held for whole transaction
- M2_BREQ  in  1  master 2 bus request, held for whole transaction
- S_SPLIT  in  1  split-capable slave requests split of current transaction
- S_SPL_READY  in  1  split slave ready to resume, level, held until resume issued
- M1_BGRANT  out  1  bus granted to master 1
- M2_BGRANT  out  1  bus granted to master 2
- M1_SPLIT  out  1  master 1 transaction is split and parked
- M2_SPLIT  out  1  master 2 transaction is split and parked
- B_SPL_RESUME  out  1  one-cycle pulse: split transaction resumed
- B_SBSY  out  1  split slave busy; other masters must not address it
- MSEL  out  1  bus mux select: 0 = master 1, 1 = master 2

Function
REQ-003 SHALL implement FSM states IDLE, OWN_M1, OWN_M2, RESUME; all outputs registered.
REQ-004 SHALL hold a split register: SPL_PEND (1 bit) and SPL_OWNER (1 bit: 0 = M1, 1 = M2).
REQ-005 IDLE: if SPL_PEND and S_SPL_READY -> RESUME; else if M1_BREQ and M1 is not split-parked -> OWN_M1; else if M2_BREQ and M2 is not split-parked -> OWN_M2; else stay.
REQ-006 Priority in IDLE: resume > M1 > M2 (fixed); a parked master's BREQ is ignored.
REQ-007 Grant latency: MxBGRANT asserts on the first rising edge after the cycle IDLE samples the request (1 cycle).
REQ-008 OWN_Mx: grant held while Mx_BREQ high; Mx_BREQ low -> IDLE, grant deasserted next edge.
REQ-009 An IDLE cycle is mandatory between two ownerships (one-cycle turnaround; no back-to-back grant).
REQ-010 OWN_Mx with S_SPLIT high and SPL_PEND low: set SPL_PEND, SPL_OWNER = x, assert Mx_SPLIT, deassert grant, -> IDLE.
REQ-011 Same cycle S_SPLIT high and Mx_BREQ low: split SHALL win (split recorded).
REQ-012 S_SPLIT in IDLE or RESUME, or while SPL_PEND already set: ignored.
REQ-013 S_SPL_READY while bus owned: no preemption; resume taken at the next IDLE, ahead of any new request.
REQ-014 RESUME (one cycle): grant to SPL_OWNER, B_SPL_RESUME = 1 for exactly that cycle, clear SPL_PEND and Mx_SPLIT, -> OWN_{SPL_OWNER}.
REQ-015 B_SBSY SHALL equal SPL_PEND (high from split capture until the RESUME cycle).
REQ-016 MSEL SHALL follow the current owner; it holds its last value in IDLE.
REQ-017 M1_BGRANT and M2_BGRANT SHALL never both be high (one-hot-or-zero, checked by assertion).
REQ-018 S_SPL_READY with SPL_PEND low: ignored.

Reset
REQ-019 RST high SHALL asynchronously force: FSM to IDLE, SPL_PEND = 0, SPL_OWNER = 0, all grants = 0, M1_SPLIT = M2_SPLIT = 0, B_SPL_RESUME = 0, B_SBSY = 0, MSEL = 0.
REQ-020 Reset mid-transaction or mid-split SHALL discard the split record; no resume is issued after release.
REQ-021 The first arbitration decision SHALL be made on the first rising edge after RST deasserts.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- M1_BREQ=M2_BREQ=1 from IDLE -> M1_BGRANT=1 one cycle later, MSEL=0; M1 drops -> 1 IDLE cycle -> M2_BGRANT=1, MSEL=1.
- M2 owns, S_SPLIT=1 one cycle -> M2_BGRANT=0, M2_SPLIT=1, B_SBSY=1; M1_BREQ=1 -> M1 granted after IDLE.
- M1 owns while split pending, S_SPL_READY=1 -> no change until M1_BREQ=0; then IDLE -> RESUME: M2_BGRANT=1, B_SPL_RESUME=1 for 1 cycle, M2_SPLIT=0, B_SBSY=0.
- S_SPLIT=1 and M1_BREQ=0 in the same cycle while OWN_M1 -> M1_SPLIT=1, SPL_OWNER=0.
- Second S_SPLIT while SPL_PEND=1 -> ignored; SPL_OWNER unchanged.
- RST pulse during a pending split -> all outputs 0; S_SPL_READY=1 afterwards -> no B_SPL_RESUME.
